// File: rtl/sc_obstacle_pkg.sv
// sc_obstacle_pkg
//  Shared definitions for the obstacle scheduler and the obstacle register bank.
//  Contents:
//   STATE_W    width of the scheduler state register
//   state_e    scheduler state encodings (3-bit, explicit values so the bank can decode them)
//   laneWidth  width of a lane index for a given lane count (at least 1 bit)
package sc_obstacle_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = 3'd0,
    S_ARB        = 3'd1,
    S_LOAD       = 3'd2,
    S_HOLD       = 3'd3,
    S_GAP        = 3'd4,
    S_CLEAR      = 3'd5,
    S_CLEAR_WAIT = 3'd6
  } state_e;

  function automatic int laneWidth(input int numLanes);
    return (numLanes <= 2) ? 1 : $clog2(numLanes);
  endfunction

endpackage

// File: rtl/sc_rr_arbiter.sv
// sc_rr_arbiter
//  Combinational round-robin pick. Scans i_ptr, i_ptr+1, ... modulo NUM_LANES and
//  returns the first lane whose request is set.
//  Ports:
//   i_req    in   NUM_LANES  request vector, active-high
//   i_ptr    in   LANE_W     lane that has highest priority this round (< NUM_LANES)
//   o_idx    out  LANE_W     chosen lane index (0 when nothing is requested)
//   o_valid  out  1          at least one request is set
module sc_rr_arbiter
  import sc_obstacle_pkg::*;
#(
  parameter int NUM_LANES = 4,
  localparam int LANE_W = laneWidth(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] i_req,
  input  logic [LANE_W-1:0]    i_ptr,
  output logic [LANE_W-1:0]    o_idx,
  output logic                 o_valid
);

  // Walk the offsets from the farthest to the nearest so that the lane closest
  // to the priority pointer is the last (and therefore winning) assignment.
  // The modulo is a single conditional subtract because i_ptr is always a
  // legal lane, which keeps non-power-of-two lane counts correct.
  always_comb begin
    int w_lane;
    o_idx   = '0;
    o_valid = 1'b0;
    w_lane  = 0;
    for (int off = NUM_LANES - 1; off >= 0; off--) begin
      w_lane = int'(i_ptr) + off;
      if (w_lane >= NUM_LANES) w_lane = w_lane - NUM_LANES;
      if (i_req[LANE_W'(w_lane)]) begin
        o_idx   = LANE_W'(w_lane);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_obstacle_scheduler.sv
// sc_obstacle_scheduler
//  Shares the obstacle register bank load/clear strobes between NUM_LANES lane
//  spawners: round-robin arbitration, one load pulse per grant, a global clear that
//  overrides everything, and GAP_CYCLES idle cycles after each completed load.
//  Ports:
//   SC_OBSTACLESCHEDULER_CLOCK_50       in   1          clock
//   SC_OBSTACLESCHEDULER_RESET_InHigh   in   1          synchronous reset, active-high
//   SC_OBSTACLESCHEDULER_enable_InHigh  in   1          game running, gates new arbitration
//   SC_OBSTACLESCHEDULER_clear_InLow    in   1          global clear request, level
//   SC_OBSTACLESCHEDULER_request_InLow  in   NUM_LANES  per-lane spawn request, level
//   SC_OBSTACLESCHEDULER_clear_OutLow   out  1          clear strobe, one-cycle pulse
//   SC_OBSTACLESCHEDULER_load_OutLow    out  1          load strobe, one-cycle pulse
//   SC_OBSTACLESCHEDULER_lane_Out       out  LANE_W     granted lane index
//   SC_OBSTACLESCHEDULER_grant_OutLow   out  NUM_LANES  one-hot grant
//   SC_OBSTACLESCHEDULER_busy_OutHigh   out  1          scheduler not idle
//  Build option: define SC_OBSTACLESCHEDULER_STARVATION_GUARD_EN to bound HOLD to
//  4*GAP_CYCLES cycles so a stuck lane cannot block the others.
module sc_obstacle_scheduler
  import sc_obstacle_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int GAP_CYCLES = 16,
  localparam int LANE_W = laneWidth(NUM_LANES)
) (
  input  logic                 SC_OBSTACLESCHEDULER_CLOCK_50,
  input  logic                 SC_OBSTACLESCHEDULER_RESET_InHigh,
  input  logic                 SC_OBSTACLESCHEDULER_enable_InHigh,
  input  logic                 SC_OBSTACLESCHEDULER_clear_InLow,
  input  logic [NUM_LANES-1:0] SC_OBSTACLESCHEDULER_request_InLow,
  output logic                 SC_OBSTACLESCHEDULER_clear_OutLow,
  output logic                 SC_OBSTACLESCHEDULER_load_OutLow,
  output logic [LANE_W-1:0]    SC_OBSTACLESCHEDULER_lane_Out,
  output logic [NUM_LANES-1:0] SC_OBSTACLESCHEDULER_grant_OutLow,
  output logic                 SC_OBSTACLESCHEDULER_busy_OutHigh
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_e               r_state;
  state_e               w_nextState;
  logic [LANE_W-1:0]    r_rrPtr;
  logic [LANE_W-1:0]    r_lane;
  logic [GAP_W-1:0]     r_gapCnt;
  logic [NUM_LANES-1:0] w_req;
  logic [NUM_LANES-1:0] w_grantHot;
  logic [LANE_W-1:0]    w_arbIdx;
  logic                 w_arbValid;
  logic                 w_clear;
  logic                 w_grantedReq;
  logic                 w_holdTimeout;

  assign w_req        = ~SC_OBSTACLESCHEDULER_request_InLow;
  assign w_clear      = ~SC_OBSTACLESCHEDULER_clear_InLow;
  assign w_grantedReq = w_req[r_lane];
  assign w_grantHot   = NUM_LANES'(1) << r_lane;

  sc_rr_arbiter #(
    .NUM_LANES(NUM_LANES)
  ) u_arbiter (
    .i_req  (w_req),
    .i_ptr  (r_rrPtr),
    .o_idx  (w_arbIdx),
    .o_valid(w_arbValid)
  );

`ifdef SC_OBSTACLESCHEDULER_STARVATION_GUARD_EN
  localparam int HOLD_LIMIT = 4 * GAP_CYCLES;
  localparam int HOLD_W     = $clog2(HOLD_LIMIT);

  logic [HOLD_W-1:0] r_holdCnt;

  // Counts cycles spent in HOLD for the current grant. It restarts whenever the
  // scheduler is anywhere else, so each grant gets a fresh HOLD_LIMIT-cycle budget
  // and the timeout fires on the last of those cycles.
  always_ff @(posedge SC_OBSTACLESCHEDULER_CLOCK_50) begin
    if (SC_OBSTACLESCHEDULER_RESET_InHigh) begin
      r_holdCnt <= '0;
    end else if (r_state == S_HOLD) begin
      r_holdCnt <= r_holdCnt + HOLD_W'(1);
    end else begin
      r_holdCnt <= '0;
    end
  end

  assign w_holdTimeout = (r_holdCnt == HOLD_W'(HOLD_LIMIT - 1));
`else
  assign w_holdTimeout = 1'b0;
`endif

  // Next-state logic. A pending clear is looked at first in every state that can
  // be interrupted; LOAD always completes so the bank never sees a truncated load.
  // Enable is only consulted when leaving IDLE, so a transaction already in
  // flight (including its GAP) runs to the end after the game stops.
  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_clear)                                                 w_nextState = S_CLEAR;
        else if (SC_OBSTACLESCHEDULER_enable_InHigh && (|w_req))     w_nextState = S_ARB;
        else                                                         w_nextState = S_IDLE;
      end
      S_ARB: begin
        if (w_clear)         w_nextState = S_CLEAR;
        else if (w_arbValid) w_nextState = S_LOAD;
        else                 w_nextState = S_IDLE;
      end
      S_LOAD:  w_nextState = S_HOLD;
      S_HOLD: begin
        if (w_clear)                            w_nextState = S_CLEAR;
        else if (!w_grantedReq || w_holdTimeout) w_nextState = S_GAP;
        else                                     w_nextState = S_HOLD;
      end
      S_GAP: begin
        if (w_clear)                        w_nextState = S_CLEAR;
        else if (r_gapCnt == GAP_W'(1))     w_nextState = S_IDLE;
        else                                w_nextState = S_GAP;
      end
      S_CLEAR: w_nextState = S_CLEAR_WAIT;
      S_CLEAR_WAIT: begin
        if (w_clear) w_nextState = S_CLEAR_WAIT;
        else         w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register plus the datapath registers it owns. The granted lane is
  // captured on the ARB->LOAD step, the round-robin pointer moves past the
  // granted lane only when the grant completes normally (HOLD->GAP), and a clear
  // throws away both the pointer and any gap in progress.
  always_ff @(posedge SC_OBSTACLESCHEDULER_CLOCK_50) begin
    if (SC_OBSTACLESCHEDULER_RESET_InHigh) begin
      r_state  <= S_IDLE;
      r_rrPtr  <= '0;
      r_lane   <= '0;
      r_gapCnt <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_ARB: begin
          if (w_nextState == S_LOAD) r_lane <= w_arbIdx;
        end
        S_HOLD: begin
          if (w_nextState == S_GAP) begin
            r_rrPtr  <= (r_lane == LANE_W'(NUM_LANES - 1)) ? '0 : r_lane + LANE_W'(1);
            r_gapCnt <= GAP_W'(GAP_CYCLES);
          end
        end
        S_GAP: r_gapCnt <= r_gapCnt - GAP_W'(1);
        S_CLEAR: begin
          r_rrPtr  <= '0;
          r_gapCnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode. Anything that is not a named state drives the same
  // quiet outputs as IDLE, so a corrupted state register never strobes the bank.
  always_comb begin
    SC_OBSTACLESCHEDULER_clear_OutLow = 1'b1;
    SC_OBSTACLESCHEDULER_load_OutLow  = 1'b1;
    SC_OBSTACLESCHEDULER_grant_OutLow = '1;
    SC_OBSTACLESCHEDULER_busy_OutHigh = 1'b0;
    case (r_state)
      S_ARB:   SC_OBSTACLESCHEDULER_busy_OutHigh = 1'b1;
      S_LOAD: begin
        SC_OBSTACLESCHEDULER_load_OutLow  = 1'b0;
        SC_OBSTACLESCHEDULER_grant_OutLow = ~w_grantHot;
        SC_OBSTACLESCHEDULER_busy_OutHigh = 1'b1;
      end
      S_HOLD: begin
        SC_OBSTACLESCHEDULER_grant_OutLow = ~w_grantHot;
        SC_OBSTACLESCHEDULER_busy_OutHigh = 1'b1;
      end
      S_GAP:   SC_OBSTACLESCHEDULER_busy_OutHigh = 1'b1;
      S_CLEAR: begin
        SC_OBSTACLESCHEDULER_clear_OutLow = 1'b0;
        SC_OBSTACLESCHEDULER_busy_OutHigh = 1'b1;
      end
      S_CLEAR_WAIT: SC_OBSTACLESCHEDULER_busy_OutHigh = 1'b1;
      default: ;
    endcase
  end

  assign SC_OBSTACLESCHEDULER_lane_Out = r_lane;

endmodule
